receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_pkg.sv | 20 ++
 rtl/rx_hold_reg.sv | 43 ++++
 rtl/receiver.sv | 98 +++++++++
 tb/tb_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared packet type, state encoding and constants for the serial receiver
package receiver_pkg;

  localparam int PACKET_BITS = 40;
  localparam int CNT_BITS    = 6;
  localparam int COUNT_BITS  = 8;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(PACKET_BITS - 1);

  typedef logic [PACKET_BITS-1:0] packet_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  localparam packet_t AUDIO_REQ_PKT = 40'h0700000000;

endpackage

// File: rtl/rx_hold_reg.sv
// rtl/rx_hold_reg.sv - one-entry valid/ready holding register with sticky overrun and packet counter
module rx_hold_reg
  import receiver_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  packet_t               pkt_data,
  output packet_t               out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic [COUNT_BITS-1:0] pkt_count
);

  logic accept;
  logic load;

  assign accept = out_valid & out_ready;
  // A slot frees up in the same cycle the consumer takes the held packet.
  assign load   = pkt_valid & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (load) begin
        out_data  <= pkt_data;
        out_valid <= 1'b1;
        pkt_count <= pkt_count + COUNT_BITS'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (pkt_valid & ~load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - serial start-bit framed 40-bit packet receiver
// Optional stop-bit check enabled by defining RX_STOP_CHECK_EN.
module receiver
  import receiver_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  output logic [PACKET_BITS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   frame_error,
  output logic [COUNT_BITS-1:0]  pkt_count
);

`ifdef RX_STOP_CHECK_EN
  localparam int SHIFT_BITS = PACKET_BITS;
`else
  // Last bit goes straight to the holding register, so the top bit is never stored.
  localparam int SHIFT_BITS = PACKET_BITS - 1;
`endif

  rx_state_t             state;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [SHIFT_BITS-1:0] shift_q;
  packet_t               shift_next;
  logic                  deliver;
  packet_t               deliver_data;

  assign shift_next = {shift_q[PACKET_BITS-2:0], sin};

`ifdef RX_STOP_CHECK_EN
  logic frame_error_q;

  assign deliver      = (state == ST_STOP) && !sin;
  assign deliver_data = shift_q;
  assign frame_error  = frame_error_q;
`else
  assign deliver      = (state == ST_DATA) && (bit_cnt == CNT_LAST);
  assign deliver_data = shift_next;
  assign frame_error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
`ifdef RX_STOP_CHECK_EN
      frame_error_q <= 1'b0;
`endif
    end else begin
`ifdef RX_STOP_CHECK_EN
      frame_error_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (sin) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift_q <= shift_next[SHIFT_BITS-1:0];
          bit_cnt <= bit_cnt + CNT_BITS'(1);
          if (bit_cnt == CNT_LAST) begin
`ifdef RX_STOP_CHECK_EN
            state <= ST_STOP;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef RX_STOP_CHECK_EN
        ST_STOP: begin
          state         <= ST_IDLE;
          frame_error_q <= sin;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_hold_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (deliver),
    .pkt_data  (deliver_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .pkt_count (pkt_count)
  );

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - randomized bench for receiver against a frame-level reference model
// Honours RX_STOP_CHECK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_receiver;
  import receiver_pkg::*;

`ifdef RX_STOP_CHECK_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_valid;
  logic        overrun;
  logic        frame_error;
  logic [7:0]  pkt_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en     = 1'b0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  receiver dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .frame_error (frame_error),
    .pkt_count   (pkt_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts owed frame bits and applies the one-slot hold rules.
  int          m_need = 0;
  logic [39:0] m_sh   = '0;
  logic        m_valid, m_ovr, m_ferr;
  logic [39:0] m_data;
  int          m_cnt;

  always @(posedge clk) begin
    bit got;
    got = 1'b0;
    if (rst) begin
      m_need = 0; m_valid = 1'b0; m_data = '0; m_ovr = 1'b0; m_ferr = 1'b0; m_cnt = 0;
    end else begin
      m_ferr = 1'b0;
      if (m_need == 0) begin
        if (sin === 1'b1) m_need = 40 + int'(STOP_EN);
      end else begin
        m_need--;
        if (m_need >= int'(STOP_EN)) m_sh = {m_sh[38:0], sin};
        if (m_need == 0) begin
          if (STOP_EN && sin === 1'b1) m_ferr = 1'b1;
          else got = 1'b1;
        end
      end
      if (got) begin
        if (!m_valid || out_ready) begin
          m_valid = 1'b1; m_data = m_sh; m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_out_valid",   out_valid,   m_valid);
      check("cyc_out_data",    out_data,    m_data);
      check("cyc_overrun",     overrun,     m_ovr);
      check("cyc_frame_error", frame_error, m_ferr);
      check("cyc_pkt_count",   pkt_count,   m_cnt[7:0]);
    end
  end

  task automatic drive(input logic b);
    @(negedge clk);
    sin = b;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sin = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Start bit, 40 data bits MSB first, stop slot, then gap idle cycles.
  // pulse raises out_ready only for the delivery edge of this frame.
  task automatic send_frame(input logic [39:0] d, input logic stop_bit, input int gap, input bit pulse);
    drive(1'b1);
    for (int i = 39; i >= 0; i--) begin
      drive(d[i]);
      if (i == 0 && pulse && !STOP_EN) out_ready = 1'b1;
    end
    drive(stop_bit);
    if (pulse) out_ready = STOP_EN;
    for (int g = 0; g < gap; g++) begin
      drive(1'b0);
      if (pulse) out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [39:0] d;
    rst = 1'b1; sin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 40'h0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_pkt_count", pkt_count, 8'd0);

    // Single frame, consumer always ready: latency and one-cycle valid.
    rst = 1'b0; out_ready = 1'b1;
    d = 40'hD999999991;
    drive(1'b1);
    for (int i = 39; i >= 0; i--) drive(d[i]);
    @(posedge clk); #1;
    check("lat_after_T40_valid", out_valid, !STOP_EN);
    drive(1'b0);
    @(posedge clk); #1;
    check("lat_after_T41_valid", out_valid, STOP_EN);
    check("single_data", out_data, 40'hD999999991);
    check("single_count", pkt_count, 8'd1);
    @(posedge clk); #1;
    check("single_valid_cleared", out_valid, 1'b0);

    // Back-to-back with 3-cycle gap, consumer stalled: second dropped.
    do_reset();
    out_ready = 1'b0;
    send_frame(40'h123456789A, 1'b0, 2, 1'b0);
    send_frame(40'hA5A5A5A5A5, 1'b0, 4, 1'b0);
    check("ovr_held_data", out_data, 40'h123456789A);
    check("ovr_valid", out_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_count", pkt_count, 8'd1);

    // Same, but consumer takes frame 1 on frame 2's delivery edge.
    do_reset();
    send_frame(40'h123456789A, 1'b0, 2, 1'b0);
    send_frame(40'hA5A5A5A5A5, 1'b0, 3, 1'b1);
    check("swap_data", out_data, 40'hA5A5A5A5A5);
    check("swap_valid", out_valid, 1'b1);
    check("swap_no_overrun", overrun, 1'b0);
    check("swap_count", pkt_count, 8'd2);

`ifdef RX_STOP_CHECK_EN
    // Bad stop bit: frame_error pulse, nothing delivered.
    do_reset();
    send_frame(40'h0F0F0F0F0F, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    check("ferr_pulse", frame_error, 1'b1);
    check("ferr_no_valid", out_valid, 1'b0);
    check("ferr_count", pkt_count, 8'd0);
    drive(1'b0);
    @(posedge clk); #1;
    check("ferr_pulse_end", frame_error, 1'b0);
`endif

    // Reset in the middle of a frame abandons it.
    do_reset();
    d = 40'hFFFFFFFFFF;
    drive(1'b1);
    for (int i = 39; i >= 20; i--) drive(d[i]);
    @(negedge clk); rst = 1'b1; sin = 1'b1;
    @(negedge clk); rst = 1'b0; sin = 1'b0;
    repeat (30) drive(1'b0);
    check("midrst_no_valid", out_valid, 1'b0);
    check("midrst_no_count", pkt_count, 8'd0);
    send_frame(AUDIO_REQ_PKT, 1'b0, 2, 1'b0);
    check("midrst_next_valid", out_valid, 1'b1);
    check("midrst_next_data", out_data, 40'h0700000000);
    check("midrst_next_count", pkt_count, 8'd1);

    // 256 accepted frames wrap the counter.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      d = {8'($urandom), 32'($urandom)};
      send_frame(d, 1'b0, 1, 1'b0);
      if (k == 254) check("wrap_count_255", pkt_count, 8'd255);
    end
    check("wrap_count_0", pkt_count, 8'd0);
    check("wrap_no_overrun", overrun, 1'b0);

    // Random frames, gaps, stop bits and consumer stalls.
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      d = {8'($urandom), 32'($urandom)};
      send_frame(d, STOP_EN && ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)), 1'b0);
    end
    rand_ready = 1'b0;
    repeat (50) drive(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
